// File: rtl/soc_interconnect_pkg.sv
// Shared helpers for the memory-port interconnect blocks.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: index-width function and the round-robin wrap-around scan.
package soc_interconnect_pkg;

  // Upper bound on requesters the scan helper handles (request vectors are zero-extended to this).
  localparam int unsigned MAX_MASTERS = 32;
  localparam int unsigned MAX_IDX_W   = 5;

  // Width of a master index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of req at or after ptr, scanning upward and wrapping at n.
  // Returns ptr when nothing is requesting.
  function automatic int unsigned rr_pick(input logic [MAX_MASTERS-1:0] req,
                                          input int unsigned            ptr,
                                          input int unsigned            n);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !found && req[idx[MAX_IDX_W-1:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_port_id_fifo.sv
// In-order FIFO of master indices for transactions awaiting a response.
// Latency: push visible at head one cycle later; head is a registered read.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full_o/empty_o.
// Ports: push_i/data_i write side, pop_i/data_o head side, full_o/empty_o/count_o status.
module mem_port_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wrap_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = wrap_inc(rd_ptr_q);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_rr_arbiter.sv
// Round-robin N:1 arbiter for the req/gnt/rvalid memory protocol with in-order response routing.
// Latency: zero-latency request/grant path; responses routed to the issuing master in the same cycle.
// Backpressure: slave request held off while the outstanding-ID FIFO is full; winner locked until granted.
// Ports: m_* per-master packed request side, s_* single slave side, outstanding_o occupancy, rsp_err_o sticky error.
module mem_port_rr_arbiter
  import soc_interconnect_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NUM_MASTERS-1:0]                 m_req_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]      m_addr_i,
  input  logic [NUM_MASTERS-1:0]                 m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]    m_be_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_wdata_i,
  output logic [NUM_MASTERS-1:0]                 m_gnt_o,
  output logic [NUM_MASTERS-1:0]                 m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                  m_rdata_o,
  output logic                                   s_req_o,
  output logic [ADDR_WIDTH-1:0]                  s_addr_o,
  output logic                                   s_we_o,
  output logic [DATA_WIDTH/8-1:0]                s_be_o,
  output logic [DATA_WIDTH-1:0]                  s_wdata_o,
  input  logic                                   s_gnt_i,
  input  logic                                   s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                  s_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   rsp_err_o
);

  localparam int unsigned IDX_W = idx_width(NUM_MASTERS);
  localparam int unsigned BE_W  = DATA_WIDTH/8;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic             lock_q, lock_d;
  logic             rsp_err_q, rsp_err_d;
  logic [IDX_W-1:0] winner, head;
  logic             fifo_full, fifo_empty, handshake, rsp_ok;

  always_comb begin
    // A pending (ungranted) request owns the port; address must stay stable until grant.
    if (lock_q) winner = lock_idx_q;
    else        winner = IDX_W'(rr_pick(MAX_MASTERS'(m_req_i), 32'(rr_ptr_q), NUM_MASTERS));

    s_req_o    = 1'b0;
    s_addr_o   = '0;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    s_wdata_o  = '0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (winner == IDX_W'(i)) begin
        // Full forces req low even when a pop lands this cycle: no rvalid->req path.
        s_req_o   = m_req_i[i] & ~fifo_full;
        s_addr_o  = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_we_o    = m_we_i[i];
        s_be_o    = m_be_i[i*BE_W +: BE_W];
        s_wdata_o = m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    handshake = s_req_o & s_gnt_i;
    rsp_ok    = s_rvalid_i & ~fifo_empty;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      m_gnt_o[i]    = handshake & (winner == IDX_W'(i));
      // Responses follow issue order, independent of who is winning now.
      m_rvalid_o[i] = rsp_ok & (head == IDX_W'(i));
    end

    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (handshake) begin
      lock_d   = 1'b0;
      rr_ptr_d = (winner == IDX_W'(NUM_MASTERS-1)) ? '0 : winner + 1'b1;
    end else if (s_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = winner;
    end
    rsp_err_d = rsp_err_q | (s_rvalid_i & fifo_empty);
  end

  assign m_rdata_o = s_rdata_i;
  assign rsp_err_o = rsp_err_q;

  mem_port_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .pop_i   (s_rvalid_i),
    .data_i  (winner),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(handshake && fifo_full));
  a_gnt_onehot:   assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(m_gnt_o));
  a_rv_onehot:    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(m_rvalid_o));

endmodule

// File: tb/tb_mem_port_rr_arbiter.sv
module tb_mem_port_rr_arbiter;

  localparam int MO = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  m_req_i;
  logic [63:0] m_addr_i;
  logic [1:0]  m_we_i;
  logic [7:0]  m_be_i;
  logic [63:0] m_wdata_i;
  logic [1:0]  m_gnt_o, m_rvalid_o;
  logic [31:0] m_rdata_o;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_be_o;
  logic        s_gnt_i, s_rvalid_i;
  logic [31:0] s_rdata_i;
  logic [1:0]  outstanding_o;
  logic        rsp_err_o;

  mem_port_rr_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
    .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
    .m_rdata_o(m_rdata_o), .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .outstanding_o(outstanding_o), .rsp_err_o(rsp_err_o));

  always #5 clk_i = ~clk_i;

  // Reference model: issue-order queue of master ids, next-preferred master, pending owner.
  int          n_vec = 0, n_err = 0;
  int          rr_ptr = 0, lock_m = -1;
  int          q[$];
  bit          err_m = 0;
  bit   [1:0]  held = '0;
  bit          rand_addr = 1;
  logic [31:0] addr_v[2], wdata_v[2];
  logic        we_v[2];
  logic [3:0]  be_v[2];
  logic [1:0]  obs_gnt, obs_rv, obs_out;
  logic        obs_sreq, obs_err;
  logic [31:0] obs_saddr, obs_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, check at posedge+4, advance the model at the edge.
  task automatic cycle(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
    int   win;
    bit   found, sreq;
    logic [1:0] eg, er;
    for (int i = 0; i < 2; i++) begin
      if (held[i]) req[i] = 1'b1;
      else if (rand_addr) begin
        addr_v[i] = $urandom; wdata_v[i] = $urandom;
        we_v[i] = 1'($urandom_range(0, 1)); be_v[i] = 4'($urandom_range(0, 15));
      end
    end
    m_req_i   = req;
    m_addr_i  = {addr_v[1], addr_v[0]};
    m_wdata_i = {wdata_v[1], wdata_v[0]};
    m_we_i    = {we_v[1], we_v[0]};
    m_be_i    = {be_v[1], be_v[0]};
    s_gnt_i = gnt; s_rvalid_i = rv; s_rdata_i = rd;
    #3;
    if (lock_m >= 0) win = lock_m;
    else begin
      win = rr_ptr; found = 0;
      for (int k = 0; k < 2; k++)
        if (!found && req[(rr_ptr + k) % 2]) begin win = (rr_ptr + k) % 2; found = 1; end
    end
    sreq = req[win] && (q.size() < MO);
    eg = (sreq && gnt) ? 2'(1 << win) : 2'b00;
    er = (rv && q.size() > 0) ? 2'(1 << q[0]) : 2'b00;
    obs_gnt = m_gnt_o; obs_rv = m_rvalid_o; obs_sreq = s_req_o; obs_out = outstanding_o;
    obs_err = rsp_err_o; obs_saddr = s_addr_o; obs_rdata = m_rdata_o;
    chk("s_req", s_req_o, sreq);
    chk("m_gnt", m_gnt_o, eg);
    chk("m_rvalid", m_rvalid_o, er);
    chk("m_rdata", m_rdata_o, rd);
    chk("outstanding", outstanding_o, q.size());
    chk("rsp_err", rsp_err_o, err_m);
    if (sreq) begin
      chk("s_addr", s_addr_o, addr_v[win]);
      chk("s_wdata", s_wdata_o, wdata_v[win]);
      chk("s_we", s_we_o, we_v[win]);
      chk("s_be", s_be_o, be_v[win]);
    end
    @(posedge clk_i);
    if (rv) begin
      if (q.size() > 0) void'(q.pop_front());
      else err_m = 1;
    end
    if (sreq && gnt) begin q.push_back(win); rr_ptr = (win + 1) % 2; lock_m = -1; end
    else if (sreq) lock_m = win;
    for (int i = 0; i < 2; i++) held[i] = req[i] && !(sreq && gnt && win == i);
    #1;
  endtask

  // Grant any held request and drain responses, bounded.
  task automatic settle();
    for (int k = 0; k < 8; k++)
      if (held != 0 || q.size() > 0) cycle(2'b00, 1'b1, q.size() > 0, $urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; m_req_i = '0; m_addr_i = '0; m_we_i = '0; m_be_i = '0; m_wdata_i = '0;
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
    for (int i = 0; i < 2; i++) begin addr_v[i] = '0; wdata_v[i] = '0; we_v[i] = 0; be_v[i] = '0; end
    #12;
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", rsp_err_o, 0);
    chk("rst_gnt", m_gnt_o, 0);
    chk("rst_rvalid", m_rvalid_o, 0);
    chk("rst_sreq", s_req_o, 0);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Fairness: both masters requesting, one-cycle memory.
    for (int i = 0; i < 6; i++) begin
      cycle(2'b11, 1'b1, i > 0, $urandom);
      chk("fair_gnt", obs_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) chk("fair_rv", obs_rv, (i % 2 == 1) ? 2'b01 : 2'b10);
    end
    cycle(2'b00, 1'b0, 1'b1, $urandom);
    chk("fair_rv_last", obs_rv, 2'b10);

    // Single master read.
    rand_addr = 0; addr_v[0] = 32'h100; we_v[0] = 1'b0;
    cycle(2'b01, 1'b1, 1'b0, 32'h0);
    chk("single_gnt", obs_gnt, 2'b01);
    chk("single_addr", obs_saddr, 32'h100);
    cycle(2'b00, 1'b0, 1'b1, 32'hDEADBEEF);
    chk("single_rv", obs_rv, 2'b01);
    chk("single_rdata", obs_rdata, 32'hDEADBEEF);

    // Lock: master 0 waits 3 cycles while master 1 joins.
    addr_v[0] = 32'h200; addr_v[1] = 32'h300;
    cycle(2'b01, 1'b0, 1'b0, 32'h0);
    chk("lock_addr0", obs_saddr, 32'h200);
    for (int i = 0; i < 2; i++) begin
      cycle(2'b11, 1'b0, 1'b0, 32'h0);
      chk("lock_addr", obs_saddr, 32'h200);
      chk("lock_gnt", obs_gnt, 2'b00);
    end
    cycle(2'b11, 1'b1, 1'b0, 32'h0);
    chk("lock_gnt_m0", obs_gnt, 2'b01);
    cycle(2'b10, 1'b1, 1'b1, 32'h0);
    chk("lock_gnt_m1", obs_gnt, 2'b10);
    cycle(2'b00, 1'b0, 1'b1, 32'h0);

    // Response routed to issuer, not current winner.
    cycle(2'b10, 1'b1, 1'b0, 32'h0);
    chk("route_gnt", obs_gnt, 2'b10);
    cycle(2'b01, 1'b0, 1'b1, 32'h1234);
    chk("route_rv", obs_rv, 2'b10);
    cycle(2'b01, 1'b1, 1'b0, 32'h0);
    cycle(2'b00, 1'b0, 1'b1, 32'h0);
    chk("route_rv2", obs_rv, 2'b01);

    // Full backpressure.
    rand_addr = 1;
    cycle(2'b11, 1'b1, 1'b0, $urandom);
    cycle(2'b11, 1'b1, 1'b0, $urandom);
    cycle(2'b11, 1'b1, 1'b0, $urandom);
    chk("full_sreq", obs_sreq, 1'b0);
    chk("full_out", obs_out, 2);
    cycle(2'b11, 1'b1, 1'b1, $urandom);
    chk("full_pop_sreq", obs_sreq, 1'b0);
    cycle(2'b11, 1'b1, 1'b0, $urandom);
    chk("full_resume_sreq", obs_sreq, 1'b1);
    chk("full_resume_out", obs_out, 1);
    settle();

    // Response with nothing outstanding.
    cycle(2'b00, 1'b0, 1'b1, 32'h55);
    chk("err_no_rv", obs_rv, 2'b00);
    cycle(2'b00, 1'b0, 1'b0, 32'h0);
    chk("err_set", obs_err, 1'b1);
    cycle(2'b01, 1'b1, 1'b0, 32'h0);
    chk("err_sticky", obs_err, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++)
      cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0), $urandom);

    // Asynchronous reset mid-burst.
    settle();
    cycle(2'b11, 1'b1, 1'b0, $urandom);
    m_req_i = '0; s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_out", outstanding_o, 0);
    chk("arst_err", rsp_err_o, 0);
    chk("arst_gnt", m_gnt_o, 0);
    chk("arst_rv", m_rvalid_o, 0);
    chk("arst_sreq", s_req_o, 0);
    q.delete(); rr_ptr = 0; lock_m = -1; err_m = 0; held = '0;
    #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    cycle(2'b00, 1'b0, 1'b1, $urandom);
    chk("post_rst_rv", obs_rv, 2'b00);
    cycle(2'b00, 1'b0, 1'b0, $urandom);
    chk("post_rst_err", obs_err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
